// File: rtl/issue_queue_pkg.sv
// ----------------------------------------------------------------------------
// issue_queue_pkg
//   Shared types and helpers for the unified issue queue.
//   - Default sizing (IQ_DEPTH, IQ_CDB_WIDTH, ROB and payload widths).
//   - iq_src_t / iq_entry_t : one queue slot (own tag, payload, two sources).
//   - rob_age()             : distance of a ROB tag from the ROB head.
//   The entry struct is laid out with the package widths, so a different
//   ROB size or payload width is changed here rather than by overriding the
//   matching parameters of the top alone.
// ----------------------------------------------------------------------------
package issue_queue_pkg;

    localparam int IQ_DEPTH     = 16;
    localparam int IQ_CDB_WIDTH = 4;
    localparam int IQ_ROB_DEPTH = 64;
    localparam int IQ_ROB_IDX_W = $clog2(IQ_ROB_DEPTH);
    localparam int IQ_PAYLOAD_W = 64;
    localparam int DISP_LANES   = 4;

    typedef logic [IQ_ROB_IDX_W-1:0] rob_idx_t;

    typedef struct packed {
        logic     in_rob;   // operand comes from a ROB entry, else from the ARF
        rob_idx_t tag;      // producing ROB entry (meaningful when in_rob)
        logic     rdy;      // operand available for reading
    } iq_src_t;

    typedef struct packed {
        logic                    valid;
        rob_idx_t                rob_idx;
        logic [IQ_PAYLOAD_W-1:0] payload;
        iq_src_t                 rs1;
        iq_src_t                 rs2;
    } iq_entry_t;

    // ROB depth is a power of two, so the modular distance is just the
    // wrapped difference of the tags.
    function automatic rob_idx_t rob_age(input rob_idx_t idx, input rob_idx_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/issue_queue_select.sv
// ----------------------------------------------------------------------------
// iq_select
//   Oldest-ready picker. Among requesting slots, grants the one with the
//   smallest age. Ages of requesters are unique, so no tie-break is needed.
//   Ports:
//     req_i       [DEPTH]         slot is valid and has both operands ready
//     age_i       [DEPTH][AGE_W]  slot age relative to the ROB head
//     gnt_valid_o                 some slot granted
//     gnt_o       [DEPTH]         one-hot grant
//     gnt_idx_o   [IDX_W]         index of the granted slot
// ----------------------------------------------------------------------------
module iq_select #(
    parameter int DEPTH = 16,
    parameter int AGE_W = 6,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            req_i,
    input  logic [DEPTH-1:0][AGE_W-1:0] age_i,
    output logic                        gnt_valid_o,
    output logic [DEPTH-1:0]            gnt_o,
    output logic [IDX_W-1:0]            gnt_idx_o
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        best_age    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && (!gnt_valid_o || age_i[i] < best_age)) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(i);
                best_age    = age_i[i];
            end
        end
        gnt_o = '0;
        if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
    end

endmodule

// File: rtl/issue_queue.sv
// ----------------------------------------------------------------------------
// issue_queue
//   Unified age-ordered issue queue. Accepts up to four renamed micro-ops per
//   cycle, tracks source readiness through CDB wakeups and issues the oldest
//   ready micro-op (by ROB age) each cycle. Operand values are not held here.
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     flush_i               drop every entry; blocks dispatch and issue
//     rob_head_i            ROB head, reference point for age
//     disp_*                four dispatch lanes (valid, own tag, payload,
//                           per-source location and ROB-ready hint)
//     disp_ready_o          room for a full group of four
//     cdb_valid_i/rob_idx_i wakeup broadcasts
//     issue_*               selected micro-op, handshake with issue_ready_i
//     occupancy_o           number of valid entries
// ----------------------------------------------------------------------------
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH         = IQ_DEPTH,
    parameter int ROB_DEPTH     = IQ_ROB_DEPTH,
    parameter int ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
    parameter int PAYLOAD_W     = IQ_PAYLOAD_W,
    parameter int CDB_WIDTH     = IQ_CDB_WIDTH,
    parameter int OCC_W         = $clog2(DEPTH + 1),
    parameter int IDX_W         = $clog2(DEPTH)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     flush_i,
    input  logic [ROB_IDX_WIDTH-1:0]                 rob_head_i,
    input  logic [DISP_LANES-1:0]                    disp_valid_i,
    output logic                                     disp_ready_o,
    input  logic [DISP_LANES-1:0][ROB_IDX_WIDTH-1:0] disp_rob_idx_i,
    input  logic [DISP_LANES-1:0][PAYLOAD_W-1:0]     disp_payload_i,
    input  logic [DISP_LANES-1:0]                    disp_rs1_in_rob_i,
    input  logic [DISP_LANES-1:0][ROB_IDX_WIDTH-1:0] disp_rs1_rob_idx_i,
    input  logic [DISP_LANES-1:0]                    disp_rs1_rob_rdy_i,
    input  logic [DISP_LANES-1:0]                    disp_rs2_in_rob_i,
    input  logic [DISP_LANES-1:0][ROB_IDX_WIDTH-1:0] disp_rs2_rob_idx_i,
    input  logic [DISP_LANES-1:0]                    disp_rs2_rob_rdy_i,
    input  logic [CDB_WIDTH-1:0]                     cdb_valid_i,
    input  logic [CDB_WIDTH-1:0][ROB_IDX_WIDTH-1:0]  cdb_rob_idx_i,
    output logic                                     issue_valid_o,
    input  logic                                     issue_ready_i,
    output logic [ROB_IDX_WIDTH-1:0]                 issue_rob_idx_o,
    output logic [PAYLOAD_W-1:0]                     issue_payload_o,
    output logic                                     issue_rs1_in_rob_o,
    output logic [ROB_IDX_WIDTH-1:0]                 issue_rs1_rob_idx_o,
    output logic                                     issue_rs2_in_rob_o,
    output logic [ROB_IDX_WIDTH-1:0]                 issue_rs2_rob_idx_o,
    output logic [OCC_W-1:0]                         occupancy_o
);

    iq_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic [DEPTH-1:0]                    sel_req;
    logic [DEPTH-1:0][ROB_IDX_WIDTH-1:0] sel_age;
    logic                                sel_valid;
    logic [DEPTH-1:0]                    sel_gnt;
    logic [IDX_W-1:0]                    sel_idx;

    logic             issue_fire;
    logic             disp_fire;
    logic [DEPTH-1:0] alloc_free;
    logic             alloc_done;
    logic [OCC_W-1:0] disp_cnt;

    function automatic logic cdb_hit(
        input logic [ROB_IDX_WIDTH-1:0]                tag,
        input logic [CDB_WIDTH-1:0]                    vld,
        input logic [CDB_WIDTH-1:0][ROB_IDX_WIDTH-1:0] idx
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++)
            if (vld[k] && idx[k] == tag) hit = 1'b1;
        return hit;
    endfunction

    // ------------------------------------------------------------------
    // Select: only registered readiness is used, so a wakeup this cycle
    // becomes eligible next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel_req[i] = ent_q[i].valid && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy;
            sel_age[i] = rob_age(ent_q[i].rob_idx, rob_head_i);
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .AGE_W (ROB_IDX_WIDTH),
        .IDX_W (IDX_W)
    ) u_select (
        .req_i       (sel_req),
        .age_i       (sel_age),
        .gnt_valid_o (sel_valid),
        .gnt_o       (sel_gnt),
        .gnt_idx_o   (sel_idx)
    );

    assign issue_valid_o       = sel_valid && !flush_i;
    assign issue_fire          = issue_valid_o && issue_ready_i;
    assign issue_rob_idx_o     = ent_q[sel_idx].rob_idx;
    assign issue_payload_o     = ent_q[sel_idx].payload;
    assign issue_rs1_in_rob_o  = ent_q[sel_idx].rs1.in_rob;
    assign issue_rs1_rob_idx_o = ent_q[sel_idx].rs1.tag;
    assign issue_rs2_in_rob_o  = ent_q[sel_idx].rs2.in_rob;
    assign issue_rs2_rob_idx_o = ent_q[sel_idx].rs2.tag;

    // Space is judged on registered occupancy only; a slot freed by an issue
    // this cycle is not counted until next cycle.
    assign disp_ready_o = (occ_q <= OCC_W'(DEPTH - DISP_LANES));
    assign disp_fire    = disp_ready_o && !flush_i;
    assign occupancy_o  = occ_q;

    // ------------------------------------------------------------------
    // Next state: wakeup, issue free, dispatch allocate, flush.
    // ------------------------------------------------------------------
    always_comb begin
        ent_d      = ent_q;
        disp_cnt   = '0;
        alloc_done = 1'b0;
        // Allocation looks at slots free at the start of the cycle.
        for (int i = 0; i < DEPTH; i++) alloc_free[i] = !ent_q[i].valid;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                if (ent_q[i].rs1.in_rob && cdb_hit(ent_q[i].rs1.tag, cdb_valid_i, cdb_rob_idx_i))
                    ent_d[i].rs1.rdy = 1'b1;
                if (ent_q[i].rs2.in_rob && cdb_hit(ent_q[i].rs2.tag, cdb_valid_i, cdb_rob_idx_i))
                    ent_d[i].rs2.rdy = 1'b1;
                if (issue_fire && sel_gnt[i])
                    ent_d[i].valid = 1'b0;
            end
        end

        // Lanes in ascending order each take the lowest free slot. disp_ready_o
        // guarantees a slot for every lane.
        if (disp_fire) begin
            for (int l = 0; l < DISP_LANES; l++) begin
                if (disp_valid_i[l]) begin
                    alloc_done = 1'b0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (!alloc_done && alloc_free[j]) begin
                            alloc_done             = 1'b1;
                            alloc_free[j]          = 1'b0;
                            ent_d[j].valid         = 1'b1;
                            ent_d[j].rob_idx       = disp_rob_idx_i[l];
                            ent_d[j].payload       = disp_payload_i[l];
                            ent_d[j].rs1.in_rob    = disp_rs1_in_rob_i[l];
                            ent_d[j].rs1.tag       = disp_rs1_rob_idx_i[l];
                            ent_d[j].rs1.rdy       = !disp_rs1_in_rob_i[l] || disp_rs1_rob_rdy_i[l] ||
                                                     cdb_hit(disp_rs1_rob_idx_i[l], cdb_valid_i, cdb_rob_idx_i);
                            ent_d[j].rs2.in_rob    = disp_rs2_in_rob_i[l];
                            ent_d[j].rs2.tag       = disp_rs2_rob_idx_i[l];
                            ent_d[j].rs2.rdy       = !disp_rs2_in_rob_i[l] || disp_rs2_rob_rdy_i[l] ||
                                                     cdb_hit(disp_rs2_rob_idx_i[l], cdb_valid_i, cdb_rob_idx_i);
                        end
                    end
                    disp_cnt = disp_cnt + OCC_W'(1);
                end
            end
        end

        occ_d = occ_q + disp_cnt - OCC_W'(issue_fire);

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            occ_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_q <= '0;
            occ_q <= '0;
        end else begin
            ent_q <= ent_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int RW    = 6;
    localparam int RD    = 64;
    localparam int PW    = 64;
    localparam int CW    = 4;

    logic                  clk = 1'b0;
    logic                  rst, flush;
    logic [RW-1:0]         rob_head;
    logic [3:0]            disp_valid;
    logic                  disp_ready;
    logic [3:0][RW-1:0]    disp_rob, disp_t1, disp_t2;
    logic [3:0][PW-1:0]    disp_pay;
    logic [3:0]            disp_in1, disp_rr1, disp_in2, disp_rr2;
    logic [CW-1:0]         cdb_valid;
    logic [CW-1:0][RW-1:0] cdb_idx;
    logic                  iss_valid, iss_ready;
    logic [RW-1:0]         iss_rob, iss_t1, iss_t2;
    logic [PW-1:0]         iss_pay;
    logic                  iss_in1, iss_in2;
    logic [4:0]            occ;

    issue_queue dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .rob_head_i          (rob_head),
        .disp_valid_i        (disp_valid),
        .disp_ready_o        (disp_ready),
        .disp_rob_idx_i      (disp_rob),
        .disp_payload_i      (disp_pay),
        .disp_rs1_in_rob_i   (disp_in1),
        .disp_rs1_rob_idx_i  (disp_t1),
        .disp_rs1_rob_rdy_i  (disp_rr1),
        .disp_rs2_in_rob_i   (disp_in2),
        .disp_rs2_rob_idx_i  (disp_t2),
        .disp_rs2_rob_rdy_i  (disp_rr2),
        .cdb_valid_i         (cdb_valid),
        .cdb_rob_idx_i       (cdb_idx),
        .issue_valid_o       (iss_valid),
        .issue_ready_i       (iss_ready),
        .issue_rob_idx_o     (iss_rob),
        .issue_payload_o     (iss_pay),
        .issue_rs1_in_rob_o  (iss_in1),
        .issue_rs1_rob_idx_o (iss_t1),
        .issue_rs2_in_rob_o  (iss_in2),
        .issue_rs2_rob_idx_o (iss_t2),
        .occupancy_o         (occ)
    );

    always #5 clk = ~clk;

    // Reference model: an unordered bag of in-flight micro-ops.
    typedef struct {
        int          rob;
        logic [PW-1:0] pay;
        bit          in1, in2, rdy1, rdy2;
        int          t1, t2;
    } mop_t;

    mop_t mdl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cdb_hit(input int t);
        for (int k = 0; k < CW; k++)
            if (cdb_valid[k] && int'(cdb_idx[k]) == t) return 1'b1;
        return 1'b0;
    endfunction

    // Oldest ready op: smallest (rob - head) mod ROB depth.
    task automatic model_pick(output bit found, output int idx);
        int best;
        found = 1'b0; idx = 0; best = RD;
        foreach (mdl[i]) begin
            int age;
            age = (mdl[i].rob - int'(rob_head) + RD) % RD;
            if (mdl[i].rdy1 && mdl[i].rdy2 && age < best) begin
                best = age; idx = i; found = 1'b1;
            end
        end
    endtask

    task automatic clr();
        rst = 0; flush = 0; iss_ready = 0;
        disp_valid = '0; disp_rob = '0; disp_pay = '0;
        disp_in1 = '0; disp_t1 = '0; disp_rr1 = '0;
        disp_in2 = '0; disp_t2 = '0; disp_rr2 = '0;
        cdb_valid = '0; cdb_idx = '0;
    endtask

    task automatic lane(input int l, input int rob, input bit in1, input int t1, input bit r1,
                        input bit in2, input int t2, input bit r2);
        disp_valid[l] = 1'b1;
        disp_rob[l]   = RW'(rob);
        disp_pay[l]   = {$urandom, $urandom};
        disp_in1[l] = in1; disp_t1[l] = RW'(t1); disp_rr1[l] = r1;
        disp_in2[l] = in2; disp_t2[l] = RW'(t2); disp_rr2[l] = r2;
    endtask

    // One cycle: compare DUT against model with current inputs, clock,
    // then advance the model with the same inputs.
    task automatic step();
        bit f, drdy;
        int k;
        #1;
        model_pick(f, k);
        if (flush) f = 1'b0;
        drdy = (DEPTH - mdl.size()) >= 4;
        chk("occupancy", 64'(occ), 64'(mdl.size()));
        chk("disp_ready", 64'(disp_ready), 64'(drdy));
        chk("issue_valid", 64'(iss_valid), 64'(f));
        if (f) begin
            chk("issue_rob", 64'(iss_rob), 64'(mdl[k].rob));
            chk("issue_payload", iss_pay, mdl[k].pay);
            chk("issue_rs1", {57'd0, iss_in1, iss_t1}, 64'({mdl[k].in1, RW'(mdl[k].t1)}));
            chk("issue_rs2", {57'd0, iss_in2, iss_t2}, 64'({mdl[k].in2, RW'(mdl[k].t2)}));
        end
        @(posedge clk);
        if (rst || flush) begin
            mdl.delete();
        end else begin
            foreach (mdl[i]) begin
                if (mdl[i].in1 && cdb_hit(mdl[i].t1)) mdl[i].rdy1 = 1'b1;
                if (mdl[i].in2 && cdb_hit(mdl[i].t2)) mdl[i].rdy2 = 1'b1;
            end
            if (f && iss_ready) mdl.delete(k);
            if (drdy) begin
                for (int l = 0; l < 4; l++) begin
                    if (disp_valid[l]) begin
                        mop_t m;
                        m.rob = int'(disp_rob[l]); m.pay = disp_pay[l];
                        m.in1 = disp_in1[l]; m.t1 = int'(disp_t1[l]);
                        m.in2 = disp_in2[l]; m.t2 = int'(disp_t2[l]);
                        m.rdy1 = !m.in1 || disp_rr1[l] || cdb_hit(m.t1);
                        m.rdy2 = !m.in2 || disp_rr2[l] || cdb_hit(m.t2);
                        mdl.push_back(m);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_w[3];
        bit [RD-1:0] used;
        exp_w = '{61, 62, 1};
        clr(); rob_head = '0; rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
        step();                                   // reset values

        // Four ready ops, issued oldest first
        lane(0, 3, 0, 0, 0, 0, 0, 0); lane(1, 0, 0, 0, 0, 0, 0, 0);
        lane(2, 2, 0, 0, 0, 0, 0, 0); lane(3, 1, 0, 0, 0, 0, 0, 0);
        step();
        clr(); iss_ready = 1;
        #1 chk("basic_occ", 64'(occ), 64'd4);
        for (int i = 0; i < 4; i++) begin
            #1 chk("basic_order", 64'(iss_rob), 64'(i));
            step();
        end
        step();

        // Wakeup at N+2 -> issue at N+3
        lane(0, 10, 1, 5, 0, 0, 0, 0);
        step();
        clr(); iss_ready = 1;
        #1 chk("wk_n1_valid", 64'(iss_valid), 64'd0);
        step();
        cdb_valid[0] = 1; cdb_idx[0] = 6'd5;
        #1 chk("wk_n2_valid", 64'(iss_valid), 64'd0);
        step();
        clr(); iss_ready = 1;
        #1 chk("wk_n3_valid", 64'(iss_valid), 64'd1);
        chk("wk_n3_rob", 64'(iss_rob), 64'd10);
        step();

        // Same-cycle dispatch + CDB match
        clr(); lane(0, 20, 0, 0, 0, 1, 9, 0);
        cdb_valid[2] = 1; cdb_idx[2] = 6'd9;
        step();
        clr(); iss_ready = 1;
        #1 chk("samecyc_valid", 64'(iss_valid), 64'd1);
        chk("samecyc_rob", 64'(iss_rob), 64'd20);
        step();

        // Wrap-around age
        clr(); rob_head = 6'd60;
        lane(0, 62, 0, 0, 0, 0, 0, 0); lane(1, 1, 0, 0, 0, 0, 0, 0); lane(2, 61, 0, 0, 0, 0, 0, 0);
        step();
        clr(); iss_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("wrap_order", 64'(iss_rob), 64'(exp_w[i]));
            step();
        end

        // Fill to DEPTH-3, stall, then free one
        clr(); rob_head = '0;
        for (int g = 0; g < 3; g++) begin
            for (int l = 0; l < 4; l++) lane(l, g * 4 + l, 0, 0, 0, 0, 0, 0);
            step();
            clr();
        end
        lane(0, 12, 0, 0, 0, 0, 0, 0);
        step();
        clr();
        #1 chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_occ", 64'(occ), 64'd13);
        for (int i = 0; i < 3; i++) step();       // stalled, nothing lost
        iss_ready = 1;
        step();
        clr();
        #1 chk("freed_ready", 64'(disp_ready), 64'd1);
        chk("freed_occ", 64'(occ), 64'd12);

        // Flush with dispatch and issue
        flush = 1; iss_ready = 1; lane(0, 40, 0, 0, 0, 0, 0, 0);
        #1 chk("flush_ivalid", 64'(iss_valid), 64'd0);
        step();
        clr();
        #1 chk("flush_occ", 64'(occ), 64'd0);
        step();

        // Mid-operation reset
        for (int l = 0; l < 4; l++) lane(l, 30 + l, 0, 0, 0, 0, 0, 0);
        step();
        clr(); rst = 1; iss_ready = 1; lane(0, 50, 0, 0, 0, 0, 0, 0);
        step();
        clr();
        #1 chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_ivalid", 64'(iss_valid), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clr();
            if ($urandom_range(0, 15) == 0) rob_head = RW'($urandom);
            used = '0;
            foreach (mdl[i]) used[mdl[i].rob] = 1'b1;
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int t;
                    do t = $urandom_range(0, RD - 1); while (used[t]);
                    used[t] = 1'b1;
                    lane(l, t, $urandom_range(0, 1) == 1, $urandom_range(0, RD - 1), $urandom_range(0, 3) == 0,
                               $urandom_range(0, 1) == 1, $urandom_range(0, RD - 1), $urandom_range(0, 3) == 0);
                end
            end
            for (int k = 0; k < CW; k++) begin
                cdb_valid[k] = $urandom_range(0, 1) == 1;
                if (mdl.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int e;
                    e = $urandom_range(0, mdl.size() - 1);
                    cdb_idx[k] = RW'($urandom_range(0, 1) == 1 ? mdl[e].t1 : mdl[e].t2);
                end else begin
                    cdb_idx[k] = RW'($urandom);
                end
            end
            iss_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 63) == 0;
            rst       = $urandom_range(0, 255) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
